sram_req_adapter: RTL and testbench

Valid/ready front end for the single-port SRAM primitive: accepts read/write requests on a handshaked channel, drives the SRAM's one-cycle-latency `req/write/addr/wdata/wmask` port, and returns every request's result in order on a handshaked response channel. It sits directly upstream of the 1-port RAM wrapper. It absorbs the fixed read latency with a small response FIFO, supports full back-to-back throughput, and flags out-of-range addresses when `Depth` is not a power of two.

---
 rtl/sram_req_adapter.sv | 154 +++++++++++++++
 tb/tb_sram_req_adapter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_adapter.sv
// Valid/ready request front end for a single-port, one-cycle-latency SRAM.
// Responses come back in order through a small FIFO sized to the credit limit.
module sram_req_adapter #(
    parameter  int Width           = 32,
    parameter  int Depth           = 512,
    parameter  int DataBitsPerMask = 8,
    parameter  int RspDepth        = 2,
    localparam int Aw              = $clog2(Depth),
    localparam int Mw              = Width / DataBitsPerMask
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Mw-1:0]    req_wmask_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_write_o,
    output logic             rsp_err_o,

    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);

    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);

    localparam logic [CntW-1:0] RspDepthC = CntW'(RspDepth);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(RspDepth - 1);
    localparam logic [Aw:0]     DepthC    = (Aw + 1)'(Depth);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both 1;
    // the source holds payload stable while valid & !ready, ready never depends on valid.
    logic            acc;
    logic            pop;
    logic            push;
    logic            in_range;
    logic            rsp_valid;
    logic [CntW:0]   occ;
    logic [CntW:0]   occ_after_pop;

    logic            inflight_q, inflight_d;
    logic            if_write_q, if_write_d;
    logic            if_err_q,   if_err_d;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic [Width-1:0] fifo_rdata_q [RspDepth];
    logic             fifo_write_q [RspDepth];
    logic             fifo_err_q   [RspDepth];
    logic [Width-1:0] push_rdata;

    assign in_range  = ({1'b0, req_addr_i} < DepthC);
    assign rsp_valid = !rst_i && (count_q != '0);
    assign pop       = rsp_valid && rsp_ready_i;

    // Credit counts the in-flight slot too, and a same-cycle pop frees one slot.
    assign occ           = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign occ_after_pop = occ - {{CntW{1'b0}}, pop};
    assign req_ready_o   = !rst_i && (occ_after_pop < {1'b0, RspDepthC});
    assign acc           = req_valid_i && req_ready_o;

    assign ram_req_o   = acc && in_range;
    assign ram_write_o = req_write_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;

    always_comb begin
        ram_wmask_o = '0;
        for (int i = 0; i < Mw; i++) begin
            ram_wmask_o[i*DataBitsPerMask +: DataBitsPerMask] = {DataBitsPerMask{req_wmask_i[i]}};
        end
    end

    always_comb begin
        inflight_d = acc;
        if_write_d = acc && req_write_i;
        if_err_d   = acc && !in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            if_write_q <= 1'b0;
            if_err_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if_write_q <= if_write_d;
            if_err_q   <= if_err_d;
        end
    end

    assign push       = inflight_q;
    assign push_rdata = (!if_write_q && !if_err_q) ? ram_rdata_i : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once count_q covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rdata_q[wr_ptr_q] <= push_rdata;
            fifo_write_q[wr_ptr_q] <= if_write_q;
            fifo_err_q[wr_ptr_q]   <= if_err_q;
        end
    end

    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_valid ? fifo_rdata_q[rd_ptr_q] : '0;
    assign rsp_write_o = rsp_valid ? fifo_write_q[rd_ptr_q] : 1'b0;
    assign rsp_err_o   = rsp_valid ? fifo_err_q[rd_ptr_q]   : 1'b0;

    no_push_into_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (count_q == RspDepthC) && !pop));

endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter: vector table, hand-built corner sequences and
// random traffic scored against an in-order shadow-memory model.
module tb_sram_req_adapter;

    localparam int Width    = 32;
    localparam int Depth    = 10;
    localparam int Dbpm     = 8;
    localparam int RspDepth = 2;
    localparam int Aw       = 4;
    localparam int Mw       = 4;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_write_i;
    logic [Aw-1:0]    req_addr_i;
    logic [Width-1:0] req_wdata_i;
    logic [Mw-1:0]    req_wmask_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [Width-1:0] rsp_rdata_o;
    logic             rsp_write_o;
    logic             rsp_err_o;
    logic             ram_req_o;
    logic             ram_write_o;
    logic [Aw-1:0]    ram_addr_o;
    logic [Width-1:0] ram_wdata_o;
    logic [Width-1:0] ram_wmask_o;
    logic [Width-1:0] ram_rdata_i = 32'hA5A5_0F0F;

    always #5 clk = ~clk;

    sram_req_adapter #(
        .Width(Width), .Depth(Depth), .DataBitsPerMask(Dbpm), .RspDepth(RspDepth)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_write_o(rsp_write_o), .rsp_err_o(rsp_err_o),
        .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic logic [Width-1:0] init_word(input int i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    function automatic logic [Width-1:0] expand(input logic [Mw-1:0] m);
        logic [Width-1:0] r = '0;
        for (int i = 0; i < Mw; i++) if (m[i]) r = r | (32'hFF << (8 * i));
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM primitive: one-cycle read latency, bit-masked writes
    logic [Width-1:0] ram_mem [16];
    logic             ram_init_done = 1'b0;
    always @(posedge clk) begin
        cyc++;
        if (!ram_init_done) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end else if (ram_req_o) begin
            if (ram_write_o)
                ram_mem[ram_addr_o] <= (ram_mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            else
                ram_rdata_i <= ram_mem[ram_addr_o];
        end
    end

    // Reference model: shadow memory updated at accept, expected {rdata, write, err} queue
    logic [Width-1:0]   ref_mem [16];
    logic [Width+1:0]   exp_q [$];
    int                 acc_cycles [$];
    int                 pop_cycles [$];
    logic               stall_prev = 1'b0;
    logic [Width+1:0]   stall_word;
    logic               m_acc, m_pop, m_inr;

    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            m_acc = req_valid_i && req_ready_o;
            m_pop = rsp_valid_o && rsp_ready_i;
            m_inr = (int'(req_addr_i) < Depth);
            check("ram_req", ram_req_o, m_acc && m_inr);
            if (stall_prev) begin
                check("hold_valid", rsp_valid_o, 1);
                check("hold_payload", {rsp_rdata_o, rsp_write_o, rsp_err_o}, stall_word);
            end
            if (m_pop) begin
                check("rsp_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("rsp_payload", {rsp_rdata_o, rsp_write_o, rsp_err_o}, exp_q.pop_front());
                pop_cycles.push_back(cyc);
            end
            if (m_acc) begin
                acc_cycles.push_back(cyc);
                if (!m_inr) begin
                    exp_q.push_back({32'h0, req_write_i, 1'b1});
                end else if (req_write_i) begin
                    check("ram_wr_fields", {ram_write_o, ram_addr_o, ram_wdata_o}, {1'b1, req_addr_i, req_wdata_i});
                    check("ram_wmask", ram_wmask_o, expand(req_wmask_i));
                    ref_mem[req_addr_i] = (ref_mem[req_addr_i] & ~expand(req_wmask_i))
                                        | (req_wdata_i & expand(req_wmask_i));
                    exp_q.push_back({32'h0, 1'b1, 1'b0});
                end else begin
                    check("ram_rd_fields", {ram_write_o, ram_addr_o}, {1'b0, req_addr_i});
                    exp_q.push_back({ref_mem[req_addr_i], 1'b0, 1'b0});
                end
            end
            stall_prev = rsp_valid_o && !rsp_ready_i;
            stall_word = {rsp_rdata_o, rsp_write_o, rsp_err_o};
        end
    end

    task automatic send(input bit w, input logic [Aw-1:0] a, input logic [Width-1:0] d,
                        input logic [Mw-1:0] m);
        int t = 0;
        bit got = 0;
        req_write_i = w; req_addr_i = a; req_wdata_i = d; req_wmask_i = m;
        req_valid_i = 1'b1;
        while (!got && t < 60) begin
            @(negedge clk);
            got = req_ready_o;
            @(posedge clk); #1;
            t++;
        end
        req_valid_i = 1'b0;
        check("send_accepted", got, 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit               write;
        logic [Aw-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Mw-1:0]    wmask;
        bit               exp_ram_req;
        logic [Width-1:0] exp_wmask;
        logic [Width-1:0] exp_rdata;
        bit               exp_write;
        bit               exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 4'hF, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'd5,  32'h0,        4'h0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd7,  32'h11223344, 4'hF, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'd7,  32'hAABBCCDD, 4'h5, 1'b1, 32'h00FF00FF, 32'h0,        1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'd7,  32'h0,        4'h0, 1'b1, 32'h0,        32'h11BB33DD, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd12, 32'h0,        4'h0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[6]  = '{1'b1, 4'd9,  32'hCAFEF00D, 4'hF, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd9,  32'h0,        4'h0, 1'b1, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'd10, 32'h12345678, 4'hF, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[9]  = '{1'b0, 4'd15, 32'h0,        4'h0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'd0,  32'h0,        4'hF, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'd0,  32'h77665544, 4'h2, 1'b1, 32'h0000FF00, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 32'h0,        32'h00005500, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'd5,  32'h0,        4'h0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};

        // Reset: a request is offered the whole time and must not reach the RAM
        rst_i = 1'b1; rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 4'd3;
        req_wdata_i = '0; req_wmask_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_ram_req", ram_req_o, 0);
        check("rst_rsp_fields", {rsp_rdata_o, rsp_write_o, rsp_err_o}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready_o, 1);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;

        // Vector table: one isolated request each, exact 2-cycle latency
        for (int i = 0; i < 14; i++) begin
            req_write_i = vecs[i].write; req_addr_i = vecs[i].addr;
            req_wdata_i = vecs[i].wdata; req_wmask_i = vecs[i].wmask;
            req_valid_i = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), req_ready_o, 1);
            check($sformatf("vec%0d_ram_req", i), ram_req_o, vecs[i].exp_ram_req);
            if (vecs[i].write && vecs[i].exp_ram_req)
                check($sformatf("vec%0d_wmask", i), ram_wmask_o, vecs[i].exp_wmask);
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_n1_valid", i), rsp_valid_o, 0);
            @(negedge clk);
            check($sformatf("vec%0d_n2_valid", i), rsp_valid_o, 1);
            check($sformatf("vec%0d_rsp", i), {rsp_rdata_o, rsp_write_o, rsp_err_o},
                  {vecs[i].exp_rdata, vecs[i].exp_write, vecs[i].exp_err});
            @(posedge clk); #1;
        end

        // Streaming: 16 back-to-back reads, no bubbles on either side
        acc_cycles.delete(); pop_cycles.delete();
        for (int i = 0; i < 16; i++) send(1'b0, 4'(i % Depth), '0, '0);
        wait_drain();
        check("stream_accepts", acc_cycles.size(), 16);
        check("stream_pops", pop_cycles.size(), 16);
        if (acc_cycles.size() == 16 && pop_cycles.size() == 16) begin
            check("stream_acc_span", acc_cycles[15] - acc_cycles[0], 15);
            check("stream_pop_span", pop_cycles[15] - pop_cycles[0], 15);
            check("stream_first_latency", pop_cycles[0] - acc_cycles[0], 2);
        end

        // Backpressure: 5 reads offered with the response side stalled
        for (int i = 0; i < 5; i++) send(1'b1, 4'(i), 32'h1000_0000 + i * 32'h0101_0101, 4'hF);
        wait_drain();
        rsp_ready_i = 1'b0;
        acc_cycles.delete(); pop_cycles.delete();
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b0, 4'(i), '0, '0);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("bp_accepted", acc_cycles.size(), RspDepth);
                check("bp_ready_low", req_ready_o, 0);
                check("bp_rsp_valid", rsp_valid_o, 1);
                @(posedge clk); #1;
                rsp_ready_i = 1'b1;
                @(negedge clk);
                check("bp_ready_on_pop", req_ready_o, 1);
            end
        join
        wait_drain();
        check("bp_total_accepts", acc_cycles.size(), 5);
        check("bp_total_pops", pop_cycles.size(), 5);

        // Reset while two reads are outstanding
        rsp_ready_i = 1'b0;
        send(1'b0, 4'd5, '0, '0);
        send(1'b0, 4'd7, '0, '0);
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_valid", rsp_valid_o, 0);
        check("midrst_ready", req_ready_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0; rsp_ready_i = 1'b1;
        @(negedge clk);
        check("postrst_ready", req_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            check("postrst_no_stale", rsp_valid_o, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(1'b0, 4'd5, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("fresh_valid", rsp_valid_o, 1);
        check("fresh_rdata", rsp_rdata_o, 32'hDEADBEEF);
        @(posedge clk); #1;
        wait_drain();

        // Random traffic with random response backpressure
        begin
            bit pending = 0;
            for (int c = 0; c < 400; c++) begin
                if (!pending) begin
                    req_valid_i = ($urandom_range(0, 9) < 7);
                    req_write_i = 1'($urandom_range(0, 1));
                    req_addr_i  = 4'($urandom_range(0, 15));
                    req_wdata_i = $urandom;
                    req_wmask_i = 4'($urandom_range(0, 15));
                end
                rsp_ready_i = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                pending = req_valid_i && !req_ready_o;
                @(posedge clk); #1;
            end
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
